// File: rtl/bus_gen_arbiter.sv
// rtl/bus_gen_arbiter.sv - shared-bus generator with one round-robin arbiter per bus
// Optional: define BUS_DROP_CNT_EN to add a saturating 16-bit dropped-packet counter per bus.
module bus_gen_arbiter #(
   parameter int         bits      = 1,
   parameter int         drvrs     = 4,
   parameter int         pckg_sz   = 32,
   parameter logic [7:0] broadcast = 8'hFF
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [bits*drvrs-1:0]          pndng,
   input  logic [bits*drvrs*pckg_sz-1:0]  D_pop,
   output logic [bits*drvrs-1:0]          pop,
   output logic [bits*drvrs-1:0]          push,
   output logic [bits*pckg_sz-1:0]        D_push
`ifdef BUS_DROP_CNT_EN
   ,
   output logic [bits*16-1:0]             drop_cnt
`endif
);

   localparam int IW = $clog2(drvrs);
   localparam logic [drvrs-1:0] ONE = {{(drvrs-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, POP, PUSH} state_t;

   for (genvar b = 0; b < bits; b++) begin : g_bus
      state_t               state, state_nxt;
      logic [IW-1:0]        sel, sel_nxt;
      logic [IW-1:0]        last_grant, grant_nxt;
      logic [drvrs-1:0]     pop_r, pop_nxt;
      logic [drvrs-1:0]     push_r, push_nxt;
      logic [pckg_sz-1:0]   dpush_r, dpush_nxt;
      logic [drvrs-1:0]     req;
      logic [pckg_sz-1:0]   heads [drvrs];
      logic [pckg_sz-1:0]   head;
      logic [7:0]           dest;
      logic                 found;
      logic [IW-1:0]        pick, cand;
      int                   idx;

      for (genvar d = 0; d < drvrs; d++) begin : g_head
         assign heads[d] = D_pop[(b*drvrs+d)*pckg_sz +: pckg_sz];
      end

      assign req  = pndng[b*drvrs +: drvrs];
      assign head = heads[sel];
      assign dest = head[pckg_sz-1 -: 8];

      always_ff @(posedge clk) begin
         if (!reset) begin
            state      <= IDLE;
            sel        <= '0;
            last_grant <= IW'(drvrs-1);
            pop_r      <= '0;
            push_r     <= '0;
            dpush_r    <= '0;
         end else begin
            state      <= state_nxt;
            sel        <= sel_nxt;
            last_grant <= grant_nxt;
            pop_r      <= pop_nxt;
            push_r     <= push_nxt;
            dpush_r    <= dpush_nxt;
         end
      end

      always_comb begin
         state_nxt = state;
         sel_nxt   = sel;
         grant_nxt = last_grant;
         pop_nxt   = '0;
         push_nxt  = '0;
         dpush_nxt = dpush_r;
         found     = 1'b0;
         pick      = '0;
         cand      = '0;
         idx       = 0;
         // Search starts just past the last grant so every requester gets a turn.
         for (int i = 1; i <= drvrs; i++) begin
            idx = int'(last_grant) + i;
            if (idx >= drvrs) idx = idx - drvrs;
            cand = IW'(idx);
            if (!found && req[cand]) begin
               found = 1'b1;
               pick  = cand;
            end
         end
         unique case (state)
            IDLE: begin
               if (found) begin
                  sel_nxt   = pick;
                  pop_nxt   = ONE << pick;
                  state_nxt = POP;
               end
            end
            POP: begin
               dpush_nxt = head;
               if (dest == broadcast)
                  push_nxt = ~(ONE << sel);
               else if (int'(dest) < drvrs)
                  push_nxt = ONE << dest[IW-1:0];
               state_nxt = PUSH;
            end
            PUSH: begin
               grant_nxt = sel;
               state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end

      assign pop[b*drvrs +: drvrs]       = pop_r;
      assign push[b*drvrs +: drvrs]      = push_r;
      assign D_push[b*pckg_sz +: pckg_sz] = dpush_r;

`ifdef BUS_DROP_CNT_EN
      logic [15:0] drops;
      // An empty push mask in PUSH can only mean an invalid destination.
      always_ff @(posedge clk) begin
         if (!reset)
            drops <= '0;
         else if (state == PUSH && push_r == '0 && drops != 16'hFFFF)
            drops <= drops + 16'd1;
      end
      assign drop_cnt[b*16 +: 16] = drops;
`endif
   end

endmodule

// File: tb/tb_bus_gen_arbiter.sv
// tb/tb_bus_gen_arbiter.sv - self-checking bench for bus_gen_arbiter (bits=1, drvrs=4, pckg_sz=32)
// Directed vector table, hand sequences for reset/round-robin, and random traffic against a transaction model.
module tb_bus_gen_arbiter;

   localparam int N = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [N-1:0]  pndng;
   logic [N*32-1:0] D_pop;
   logic [N-1:0]  pop;
   logic [N-1:0]  push;
   logic [31:0]   D_push;
`ifdef BUS_DROP_CNT_EN
   logic [15:0]   drop_cnt;
`endif

   int checks = 0;
   int errors = 0;
   int exp_drops = 0;

   bus_gen_arbiter #(.bits(1), .drvrs(N), .pckg_sz(32), .broadcast(8'hFF)) dut (
      .clk    (clk),
      .reset  (reset),
      .pndng  (pndng),
      .D_pop  (D_pop),
      .pop    (pop),
      .push   (push),
      .D_push (D_push)
`ifdef BUS_DROP_CNT_EN
      ,
      .drop_cnt (drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      pndng = '0;
      D_pop = '0;
      tick();
      tick();
      reset = 1'b1;
      exp_drops = 0;
   endtask

   // One full arbitration cycle starting with the DUT idle; e_pop==0 means no grant expected.
   task automatic run_txn(input logic [N-1:0] pnd, input logic [N*32-1:0] dp,
                          input logic [N-1:0] e_pop, input logic [N-1:0] e_push,
                          input logic [31:0] e_data, input logic scramble);
      logic [N*32-1:0] keep;
      pndng = pnd;
      D_pop = dp;
      tick();
      chk("pop_grant", {28'd0, pop}, {28'd0, e_pop});
      chk("push_in_pop", {28'd0, push}, 32'd0);
      if (e_pop != '0) begin
         if (scramble) begin
            pndng = N'($urandom);
            keep  = dp;
            for (int d = 0; d < N; d++)
               if (!e_pop[d]) keep[d*32 +: 32] = $urandom;
            D_pop = keep;
         end
         tick();
         chk("pop_clear", {28'd0, pop}, 32'd0);
         chk("push_mask", {28'd0, push}, {28'd0, e_push});
         chk("d_push", D_push, e_data);
         if (e_push == '0) exp_drops++;
         if (scramble) begin
            pndng = N'($urandom);
            D_pop = {$urandom, $urandom, $urandom, $urandom};
         end
         tick();
         chk("push_clear", {28'd0, push}, 32'd0);
         chk("pop_idle", {28'd0, pop}, 32'd0);
         chk("d_push_hold", D_push, e_data);
`ifdef BUS_DROP_CNT_EN
         chk("drop_cnt", {16'd0, drop_cnt}, exp_drops);
`endif
      end
   endtask

   function automatic int rr_pick(input logic [N-1:0] p, input int last);
      for (int k = 1; k <= N; k++)
         if (p[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   function automatic logic [N-1:0] exp_mask(input logic [31:0] w, input int src);
      int dst;
      dst = int'(w[31:24]);
      if (dst == 255) return N'(4'hF ^ (4'b0001 << src));
      if (dst < N) return N'(4'b0001 << dst);
      return '0;
   endfunction

   typedef struct {
      logic [N-1:0] pnd;
      logic [31:0]  word;
      logic [N-1:0] e_pop;
      logic [N-1:0] e_push;
   } vec_t;

   vec_t tbl [8];

   initial begin
      logic [N*32-1:0] dp;
      logic [31:0] w;
      int last, win, r;

      tbl[0] = '{4'b0100, 32'h01AB_CDEF, 4'b0100, 4'b0010};
      tbl[1] = '{4'b0010, 32'hFF00_1234, 4'b0010, 4'b1101};
      tbl[2] = '{4'b0001, 32'h0700_0000, 4'b0001, 4'b0000};
      tbl[3] = '{4'b1111, 32'h0300_0055, 4'b0010, 4'b1000};
      tbl[4] = '{4'b1001, 32'h0200_0000, 4'b1000, 4'b0100};
      tbl[5] = '{4'b1001, 32'h00FF_FFFF, 4'b0001, 4'b0001};
      tbl[6] = '{4'b0000, 32'h0100_0000, 4'b0000, 4'b0000};
      tbl[7] = '{4'b1000, 32'hFF00_ABCD, 4'b1000, 4'b0111};

      // Reset held with every terminal pending.
      reset = 1'b0;
      pndng = 4'b1111;
      D_pop = {4{32'h0100_0000}};
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("rst_pop", {28'd0, pop}, 32'd0);
         chk("rst_push", {28'd0, push}, 32'd0);
         chk("rst_dpush", D_push, 32'd0);
      end
      reset = 1'b1;
      tick();
      chk("first_pop", {28'd0, pop}, 32'h1);

      do_reset();
      for (int i = 0; i < 8; i++)
         run_txn(tbl[i].pnd, {4{tbl[i].word}}, tbl[i].e_pop, tbl[i].e_push, tbl[i].word, 1'b0);

      // All pending continuously: grants rotate 0,1,2,3 every third cycle.
      do_reset();
      pndng = 4'b1111;
      D_pop = '0;
      for (int i = 0; i < 12; i++) begin
         tick();
         chk("rr_pop", {28'd0, pop}, (i % 3 == 0) ? (32'h1 << (i / 3)) : 32'h0);
      end

      // Reset during POP abandons the packet and restores the pointer.
      do_reset();
      run_txn(4'b0001, {4{32'h0000_0001}}, 4'b0001, 4'b0001, 32'h0000_0001, 1'b0);
      pndng = 4'b0010;
      D_pop = {4{32'h0000_0002}};
      tick();
      chk("mid_pop", {28'd0, pop}, 32'h2);
      reset = 1'b0;
      tick();
      chk("mid_push", {28'd0, push}, 32'd0);
      chk("mid_pop_clr", {28'd0, pop}, 32'd0);
      chk("mid_dpush", D_push, 32'd0);
      reset = 1'b1;
      pndng = 4'b1111;
      tick();
      chk("mid_ptr", {28'd0, pop}, 32'h1);

      // Random traffic against a transaction-level model.
      do_reset();
      last = N - 1;
      for (int t = 0; t < 200; t++) begin
         pndng = '0;
         for (int d = 0; d < N; d++) begin
            r = $urandom_range(0, 5);
            if (r < 4)       w[31:24] = 8'(r);
            else if (r == 4) w[31:24] = 8'hFF;
            else             w[31:24] = 8'($urandom_range(4, 254));
            w[23:0] = 24'($urandom);
            dp[d*32 +: 32] = w;
         end
         r = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 15));
         win = rr_pick(N'(r), last);
         if (win < 0) begin
            run_txn('0, dp, '0, '0, 32'd0, 1'b1);
         end else begin
            w = dp[win*32 +: 32];
            run_txn(N'(r), dp, N'(4'b0001 << win), exp_mask(w, win), w, 1'b1);
            last = win;
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bus_gen_arbiter.md
Name: bus_gen_arbiter

Overview:
- Shared-bus generator and round-robin arbiter connecting `drvrs` terminals.
- Each terminal presents a first-word-fall-through input FIFO head (`D_pop`, `pndng`). The block pops one packet at a time and routes it to the addressed terminal, or to all other terminals on broadcast.
- Sits between the terminal FIFOs and terminal output queues; `bits` independent bus instances are supported.

Parameters:
- bits, 1, number of independent buses; each bus slice has its own arbiter and identical behaviour.
- drvrs, 4, number of terminals per bus (2..16).
- pckg_sz, 32, packet width in bits (>= 9).
- broadcast, 8'hFF, destination-ID value meaning "deliver to all terminals except the source".

Ports:
- clk, input, 1, single rising-edge clock.
- reset, input, 1, synchronous, active-low reset.
- pndng, input, bits*drvrs, FIFO-not-empty flags; bus b, terminal d at index b*drvrs+d.
- D_pop, input, bits*drvrs*pckg_sz, FIFO head data; slice (b*drvrs+d)*pckg_sz +: pckg_sz.
- pop, output, bits*drvrs, one-cycle pop strobe to the terminal FIFO.
- push, output, bits*drvrs, one-cycle push strobe to a terminal's receive queue.
- D_push, output, bits*pckg_sz, bus data for bus b at b*pckg_sz +: pckg_sz; common to all terminals of that bus.

Behaviour:
- Registered outputs, all updated on the rising clk edge.
- reset==0 sampled at an edge:
  - pop=0, push=0, D_push=0, state=IDLE.
  - RR pointer set so terminal 0 has first priority.
  - Reset mid-operation abandons the packet in flight: no push is issued, and a popped word is lost.
- Packet format: dest = packet[pckg_sz-1 -: 8]; remaining bits are payload, carried unchanged.
- Per-bus FSM, three states:
  - IDLE: if any pndng is set, select the first set terminal searching from last_grant+1 upward with wrap-around; record sel; go to POP. If no pndng is set, stay in IDLE.
  - POP: drive pop[sel]=1 for exactly this cycle; capture D_pop[sel] into the data register; go to PUSH.
  - PUSH: drive D_push=captured packet; drive push mask for exactly this cycle; set last_grant=sel; go to IDLE.
- Push mask:
  - dest==broadcast: every terminal except sel.
  - dest<drvrs: only terminal dest, including dest==sel (self-delivery allowed).
  - Any other dest: no push; packet dropped.
- D_push holds its last value outside PUSH; push and pop are 0 outside their states.
- Latency: pndng seen at edge t → pop high during cycle t+1 → push/D_push valid during cycle t+2.
- Throughput: one packet per 3 cycles per bus.
- pndng changing while in POP/PUSH has no effect until IDLE.
- Fairness: with all terminals pending continuously, grants rotate 0,1,2,3,0,… with no starvation.
- Buses are fully independent; simultaneous activity on different buses is allowed.
- Any pndng/push back-pressure is the consumers' responsibility; the block never stalls in PUSH.

Optional Feature:
- Macro BUS_DROP_CNT_EN.
- When defined: output port `drop_cnt` (bits*16) is added, one 16-bit counter per bus.
  - Increments in PUSH when the packet is dropped (invalid dest).
  - Saturates at 16'hFFFF.
  - Cleared by reset.
- When undefined: no port and no counter logic; dropped packets are silently discarded.

Test Plan:
- Reset: hold reset=0 for 2 cycles with pndng=4'b1111 → pop=0, push=0, D_push=0 throughout. After release, first pop is pop[0].
- Unicast: terminal 2 pending with D_pop=32'h01AB_CDEF → pop[2] one cycle later, then push=4'b0010 and D_push=32'h01AB_CDEF on the next cycle.
- Broadcast: terminal 1 pending with 32'hFF00_1234 → push=4'b1101 for one cycle, D_push=32'hFF00_1234.
- Round-robin: all four pndng held high for 12 cycles → pop sequence 0,1,2,3, one grant every 3 cycles.
- Invalid dest: terminal 0 sends 32'h0700_0000 (drvrs=4) → pop[0] asserted, push stays 0; drop_cnt=1 when BUS_DROP_CNT_EN is defined.
- Reset mid-packet: assert reset=0 during POP → next cycle push=0, state IDLE, pointer back to terminal 0.
